// File: rtl/kmkz_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : kmkz_csr_file
// Description : Machine-mode CSR file for the execute stage. Holds the
//               mcycle / minstret counters, mtvec and up to four scratch
//               registers locally; decodes, reads and computes write values
//               for the externally held CSRs (mstatus, mie, mip, mepc,
//               mcause) and hands those writes back through a write port.
//
// Ports
//   clk_i                 in   1   clock, all state updates on rising edge
//   rst_i                 in   1   asynchronous reset, active low
//   x_stall_i, x_kill_i   in   1   execute-stage stall / kill qualifiers
//   d_is_csr_i            in   1   a CSR instruction is in execute
//   d_fun_i               in   3   CSR funct3 (RW/RS/RC and immediate forms)
//   d_csr_imm_i           in   5   zimm for the immediate forms
//   d_csr_sel_i           in  12   CSR address
//   d_rs1_i               in  32   rs1 operand
//   x_retire_i            in   1   one instruction retires this cycle
//   csr_time_i            in  40   free-running time
//   csr_m*_i              in  32   current values of externally held CSRs
//   x_rd_o                out 32   old value of the selected CSR
//   x_csr_write_value_o   out 32   new value for an external CSR
//   x_csr_we_o            out  1   external CSR write strobe
//   x_csr_sel_o           out 12   external CSR address
//   x_illegal_o           out  1   illegal CSR access
//   csr_mtvec_o           out 32   current mtvec
//
// Revision    : 1.0 - initial release
// ============================================================================
module kmkz_csr_file #(
    parameter int          NUM_SCRATCH = 1,
    parameter int          CNT_WIDTH   = 64,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_is_csr_i,
    input  logic [2:0]  d_fun_i,
    input  logic [4:0]  d_csr_imm_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] d_rs1_i,
    input  logic        x_retire_i,
    input  logic [39:0] csr_time_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mip_i,
    input  logic [31:0] csr_mie_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mcause_i,
    output logic [31:0] x_rd_o,
    output logic [31:0] x_csr_write_value_o,
    output logic        x_csr_we_o,
    output logic [11:0] x_csr_sel_o,
    output logic        x_illegal_o,
    output logic [31:0] csr_mtvec_o
);

    localparam logic [11:0] c_mcycle    = 12'hB00;
    localparam logic [11:0] c_mcycleh   = 12'hB80;
    localparam logic [11:0] c_minstret  = 12'hB02;
    localparam logic [11:0] c_minstreth = 12'hB82;
    localparam logic [11:0] c_cycle     = 12'hC00;
    localparam logic [11:0] c_cycleh    = 12'hC80;
    localparam logic [11:0] c_instret   = 12'hC02;
    localparam logic [11:0] c_instreth  = 12'hC82;
    localparam logic [11:0] c_time      = 12'hC01;
    localparam logic [11:0] c_timeh     = 12'hC81;
    localparam logic [11:0] c_mtvec     = 12'h305;
    localparam logic [11:0] c_mstatus   = 12'h300;
    localparam logic [11:0] c_mie       = 12'h304;
    localparam logic [11:0] c_mip       = 12'h344;
    localparam logic [11:0] c_mepc      = 12'h341;
    localparam logic [11:0] c_mcause    = 12'h342;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_mcycle;
    logic [CNT_WIDTH-1:0] r_minstret;
    logic [31:0]          r_mtvec;

    // Counters viewed as 64 bits; bits above CNT_WIDTH read as zero.
    logic [63:0] w_mcycle64;
    logic [63:0] w_minstret64;
    assign w_mcycle64   = 64'(r_mcycle);
    assign w_minstret64 = 64'(r_minstret);

    logic [31:0] w_src;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_hit;
    logic        w_ext;
    logic        w_wr_intent;
    logic        w_illegal;
    logic        w_commit;

    // ------------------------------------------------------------------
    // Scratch registers
    // ------------------------------------------------------------------
    logic [NUM_SCRATCH-1:0]       w_scr_sel;
    logic [NUM_SCRATCH-1:0][31:0] w_scr_rdv;
    logic                         w_scr_hit;
    logic [31:0]                  w_scr_rd;

    for (genvar k = 0; k < NUM_SCRATCH; k++) begin : g_scratch
        localparam logic [11:0] c_addr = (k == 0) ? 12'h340 : 12'(12'h7C0 + k - 1);
        logic [31:0] r_val;

        assign w_scr_sel[k] = (d_csr_sel_i == c_addr);
        assign w_scr_rdv[k] = w_scr_sel[k] ? r_val : 32'h0;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                r_val <= 32'h0;
            end else if (w_commit && w_scr_sel[k]) begin
                r_val <= w_new;
            end
        end
    end

    assign w_scr_hit = |w_scr_sel;

    always_comb begin
        w_scr_rd = 32'h0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            w_scr_rd = w_scr_rd | w_scr_rdv[i];
        end
    end

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_old = 32'h0;
        w_hit = 1'b1;
        w_ext = 1'b0;
        case (d_csr_sel_i)
            c_mcycle,   c_cycle:    w_old = w_mcycle64[31:0];
            c_mcycleh,  c_cycleh:   w_old = w_mcycle64[63:32];
            c_minstret, c_instret:  w_old = w_minstret64[31:0];
            c_minstreth, c_instreth: w_old = w_minstret64[63:32];
            c_time:                 w_old = csr_time_i[31:0];
            c_timeh:                w_old = {24'h0, csr_time_i[39:32]};
            c_mtvec:                w_old = r_mtvec;
            c_mstatus: begin w_old = csr_mstatus_i; w_ext = 1'b1; end
            c_mie:     begin w_old = csr_mie_i;     w_ext = 1'b1; end
            c_mip:     begin w_old = csr_mip_i;     w_ext = 1'b1; end
            c_mepc:    begin w_old = csr_mepc_i;    w_ext = 1'b1; end
            c_mcause:  begin w_old = csr_mcause_i;  w_ext = 1'b1; end
            default: begin
                // Scratch addresses at or above NUM_SCRATCH fall out here
                // as undecoded.
                w_old = w_scr_rd;
                w_hit = w_scr_hit;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // New value, legality and commit
    // ------------------------------------------------------------------
    assign w_src = d_fun_i[2] ? {27'h0, d_csr_imm_i} : d_rs1_i;

    always_comb begin
        case (d_fun_i[1:0])
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_src;
        endcase
    end

    // Set/clear with a zero source is a pure read, so it is legal on the
    // read-only counter shadows and writes nothing.
    assign w_wr_intent = (d_fun_i[1:0] == 2'b01) || (w_src != 32'h0);

    assign w_illegal = d_is_csr_i &&
                       (!w_hit ||
                        (w_wr_intent && (d_csr_sel_i[11:10] == 2'b11)) ||
                        (d_fun_i[1:0] == 2'b00));

    assign w_commit = d_is_csr_i && !x_stall_i && !x_kill_i &&
                      !w_illegal && w_wr_intent;

    // ------------------------------------------------------------------
    // Counters and mtvec
    // ------------------------------------------------------------------
    logic        w_wr_mcyc_lo;
    logic        w_wr_mcyc_hi;
    logic        w_wr_mins_lo;
    logic        w_wr_mins_hi;
    logic [63:0] w_mcyc_wlo;
    logic [63:0] w_mcyc_whi;
    logic [63:0] w_mins_wlo;
    logic [63:0] w_mins_whi;

    assign w_wr_mcyc_lo = w_commit && (d_csr_sel_i == c_mcycle);
    assign w_wr_mcyc_hi = w_commit && (d_csr_sel_i == c_mcycleh);
    assign w_wr_mins_lo = w_commit && (d_csr_sel_i == c_minstret);
    assign w_wr_mins_hi = w_commit && (d_csr_sel_i == c_minstreth);

    // A half write replaces that half and keeps the other half as is.
    assign w_mcyc_wlo = {w_mcycle64[63:32], w_new};
    assign w_mcyc_whi = {w_new, w_mcycle64[31:0]};
    assign w_mins_wlo = {w_minstret64[63:32], w_new};
    assign w_mins_whi = {w_new, w_minstret64[31:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            r_mtvec    <= MTVEC_RESET;
        end else begin
            if (w_wr_mcyc_lo) begin
                r_mcycle <= w_mcyc_wlo[CNT_WIDTH-1:0];
            end else if (w_wr_mcyc_hi) begin
                r_mcycle <= w_mcyc_whi[CNT_WIDTH-1:0];
            end else begin
                r_mcycle <= r_mcycle + c_cnt_one;
            end

            if (w_wr_mins_lo) begin
                r_minstret <= w_mins_wlo[CNT_WIDTH-1:0];
            end else if (w_wr_mins_hi) begin
                r_minstret <= w_mins_whi[CNT_WIDTH-1:0];
            end else if (x_retire_i && !x_stall_i) begin
                r_minstret <= r_minstret + c_cnt_one;
            end

            if (w_commit && (d_csr_sel_i == c_mtvec)) begin
                r_mtvec <= {w_new[31:2], 2'b00};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign x_rd_o              = w_old;
    assign x_illegal_o         = w_illegal;
    assign x_csr_we_o          = w_commit && w_ext;
    assign x_csr_sel_o         = d_csr_sel_i;
    assign x_csr_write_value_o = w_new;
    assign csr_mtvec_o         = r_mtvec;

endmodule
`default_nettype wire

// File: tb/tb_kmkz_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_kmkz_csr_file
// Description : Self-checking bench for kmkz_csr_file (default parameters).
//               Table of single-cycle CSR accesses plus hand-written
//               counter, illegal-access and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kmkz_csr_file;

    localparam logic [2:0] c_rw  = 3'b001;
    localparam logic [2:0] c_rs  = 3'b010;
    localparam logic [2:0] c_rc  = 3'b011;
    localparam logic [2:0] c_rwi = 3'b101;
    localparam logic [2:0] c_rsi = 3'b110;
    localparam logic [2:0] c_rci = 3'b111;

    localparam logic [31:0] c_mstatus = 32'h0000_1800;
    localparam logic [31:0] c_mie     = 32'h0000_0888;
    localparam logic [31:0] c_mip     = 32'h0000_0080;
    localparam logic [31:0] c_mepc    = 32'h0000_2000;
    localparam logic [31:0] c_mcause  = 32'h8000_000B;
    localparam logic [39:0] c_time    = 40'hAB_1234_5678;

    logic        clk;
    logic        rst_n;
    logic        x_stall, x_kill, d_is_csr, x_retire;
    logic [2:0]  d_fun;
    logic [4:0]  d_imm;
    logic [11:0] d_sel;
    logic [31:0] d_rs1;
    logic [31:0] x_rd, x_wv, mtvec;
    logic        x_we, x_ill;
    logic [11:0] x_sel;

    int n_tests = 0;
    int n_fail  = 0;

    kmkz_csr_file dut (
        .clk_i               (clk),
        .rst_i               (rst_n),
        .x_stall_i           (x_stall),
        .x_kill_i            (x_kill),
        .d_is_csr_i          (d_is_csr),
        .d_fun_i             (d_fun),
        .d_csr_imm_i         (d_imm),
        .d_csr_sel_i         (d_sel),
        .d_rs1_i             (d_rs1),
        .x_retire_i          (x_retire),
        .csr_time_i          (c_time),
        .csr_mstatus_i       (c_mstatus),
        .csr_mip_i           (c_mip),
        .csr_mie_i           (c_mie),
        .csr_mepc_i          (c_mepc),
        .csr_mcause_i        (c_mcause),
        .x_rd_o              (x_rd),
        .x_csr_write_value_o (x_wv),
        .x_csr_we_o          (x_we),
        .x_csr_sel_o         (x_sel),
        .x_illegal_o         (x_ill),
        .csr_mtvec_o         (mtvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_csr;
        logic [2:0]  fun;
        logic [11:0] sel;
        logic [31:0] rs1;
        logic [4:0]  imm;
        logic        stall;
        logic        kill;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic        exp_we;
        logic [31:0] exp_wv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic is_csr, logic [2:0] fun, logic [11:0] sel,
                                logic [31:0] rs1, logic [4:0] imm, logic stall,
                                logic kill, logic [31:0] exp_rd, logic exp_ill,
                                logic exp_we, logic [31:0] exp_wv);
        vec_t v;
        v.is_csr = is_csr; v.fun = fun; v.sel = sel; v.rs1 = rs1; v.imm = imm;
        v.stall = stall; v.kill = kill; v.exp_rd = exp_rd; v.exp_ill = exp_ill;
        v.exp_we = exp_we; v.exp_wv = exp_wv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present an operation on the next falling edge; outputs settle 1 ns later.
    task automatic drive(input logic is_csr, input logic [2:0] fun, input logic [11:0] sel,
                         input logic [31:0] rs1, input logic [4:0] imm);
        @(negedge clk);
        d_is_csr = is_csr; d_fun = fun; d_sel = sel; d_rs1 = rs1; d_imm = imm;
        x_stall = 1'b0; x_kill = 1'b0;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, c_rs, 12'h000, 32'h0, 5'h0);
    endtask

    initial begin
        rst_n = 1'b0; x_stall = 1'b0; x_kill = 1'b0; x_retire = 1'b0;
        d_is_csr = 1'b1; d_fun = c_rs; d_sel = 12'hB00; d_rs1 = 32'h0; d_imm = 5'h0;

        // Reset state
        @(negedge clk); #1;
        check("reset_mcycle", x_rd, 32'h0);
        check("reset_mtvec", mtvec, 32'h0000_0100);
        rst_n = 1'b1;
        d_is_csr = 1'b0;

        // Ten idle cycles after reset release
        repeat (9) @(negedge clk);
        drive(1'b1, c_rs, 12'hB00, 32'h0, 5'h0);
        check("mcycle_after_10", x_rd, 32'd10);
        drive(1'b1, c_rs, 12'hB02, 32'h0, 5'h0);
        check("minstret_idle", x_rd, 32'd0);

        // Single-cycle access table
        vecs.push_back(mk(1, c_rs,   12'h340, 32'h0F, 0, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, c_rc,   12'h340, 32'h03, 0, 0, 0, 32'h0F, 0, 0, 0));
        vecs.push_back(mk(1, c_rs,   12'h340, 32'h0, 0, 0, 0, 32'h0C, 0, 0, 0));
        vecs.push_back(mk(1, c_rw,   12'h340, 32'hDEAD_BEEF, 0, 0, 1, 32'h0C, 0, 0, 0));
        vecs.push_back(mk(1, c_rw,   12'h340, 32'h1234, 0, 1, 0, 32'h0C, 0, 0, 0));
        vecs.push_back(mk(1, c_rsi,  12'h340, 32'h0, 5'h10, 0, 0, 32'h0C, 0, 0, 0));
        vecs.push_back(mk(1, c_rci,  12'h340, 32'h0, 5'h04, 0, 0, 32'h1C, 0, 0, 0));
        vecs.push_back(mk(1, c_rs,   12'h340, 32'h0, 0, 0, 0, 32'h18, 0, 0, 0));
        vecs.push_back(mk(1, c_rwi,  12'h305, 32'h0, 5'h13, 0, 0, 32'h100, 0, 0, 0));
        vecs.push_back(mk(1, c_rs,   12'h305, 32'h0, 0, 0, 0, 32'h10, 0, 0, 0));
        vecs.push_back(mk(1, c_rw,   12'h7C0, 32'h1, 0, 0, 0, 32'h0, 1, 0, 0));
        vecs.push_back(mk(1, c_rs,   12'h300, 32'h8, 0, 0, 0, c_mstatus, 0, 1, 32'h1808));
        vecs.push_back(mk(1, c_rw,   12'h341, 32'h80, 0, 0, 0, c_mepc, 0, 1, 32'h80));
        vecs.push_back(mk(1, c_rw,   12'h341, 32'h80, 0, 0, 1, c_mepc, 0, 0, 0));
        vecs.push_back(mk(1, c_rc,   12'h342, 32'h0, 0, 0, 0, c_mcause, 0, 0, 0));
        vecs.push_back(mk(1, c_rc,   12'h344, 32'hFFFF, 0, 0, 0, c_mip, 0, 1, 32'h0));
        vecs.push_back(mk(1, c_rsi,  12'h304, 32'h0, 5'h01, 0, 0, c_mie, 0, 1, 32'h889));
        vecs.push_back(mk(1, 3'b000, 12'h340, 32'h5, 0, 0, 0, 32'h18, 1, 0, 0));
        vecs.push_back(mk(1, 3'b100, 12'h340, 32'h5, 0, 0, 0, 32'h18, 1, 0, 0));
        vecs.push_back(mk(1, c_rw,   12'h123, 32'h5, 0, 0, 0, 32'h0, 1, 0, 0));
        vecs.push_back(mk(1, c_rs,   12'hC01, 32'h0, 0, 0, 0, 32'h1234_5678, 0, 0, 0));
        vecs.push_back(mk(1, c_rs,   12'hC81, 32'h0, 0, 0, 0, 32'h0000_00AB, 0, 0, 0));
        vecs.push_back(mk(1, c_rw,   12'hC01, 32'h5, 0, 0, 0, 32'h1234_5678, 1, 0, 0));
        vecs.push_back(mk(0, c_rw,   12'h340, 32'hFFFF, 0, 0, 0, 32'h18, 0, 0, 0));
        vecs.push_back(mk(1, c_rs,   12'h340, 32'h0, 0, 0, 0, 32'h18, 0, 0, 0));
        vecs.push_back(mk(1, c_rci,  12'hC01, 32'h0, 5'h00, 0, 0, 32'h1234_5678, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            d_is_csr = vecs[i].is_csr; d_fun = vecs[i].fun; d_sel = vecs[i].sel;
            d_rs1 = vecs[i].rs1; d_imm = vecs[i].imm;
            x_stall = vecs[i].stall; x_kill = vecs[i].kill;
            #1;
            check($sformatf("vec%0d_rd", i), x_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_ill", i), {31'h0, x_ill}, {31'h0, vecs[i].exp_ill});
            check($sformatf("vec%0d_we", i), {31'h0, x_we}, {31'h0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_wv", i), x_wv, vecs[i].exp_wv);
                check($sformatf("vec%0d_sel", i), {20'h0, x_sel}, {20'h0, vecs[i].sel});
            end
        end
        idle();
        check("mtvec_out", mtvec, 32'h10);

        // mcycle low write then carry into the high half
        drive(1'b1, c_rw, 12'hB80, 32'h0, 5'h0);
        drive(1'b1, c_rw, 12'hB00, 32'hFFFF_FFFF, 5'h0);
        drive(1'b1, c_rs, 12'hB00, 32'h0, 5'h0);
        check("mcycle_lo_written", x_rd, 32'hFFFF_FFFF);
        drive(1'b1, c_rs, 12'hB00, 32'h0, 5'h0);
        check("mcycle_lo_wrapped", x_rd, 32'h0);
        drive(1'b1, c_rs, 12'hB80, 32'h0, 5'h0);
        check("mcycleh_carry", x_rd, 32'h1);

        // Half write holds the other half (no increment that cycle)
        drive(1'b1, c_rw, 12'hB00, 32'h100, 5'h0);
        drive(1'b1, c_rw, 12'hB80, 32'h5, 5'h0);
        drive(1'b1, c_rs, 12'hB00, 32'h0, 5'h0);
        check("mcycle_lo_held", x_rd, 32'h100);
        drive(1'b1, c_rs, 12'hC80, 32'h0, 5'h0);
        check("cycleh_read", x_rd, 32'h5);

        // Full 64-bit wrap to zero
        drive(1'b1, c_rw, 12'hB80, 32'hFFFF_FFFF, 5'h0);
        drive(1'b1, c_rw, 12'hB00, 32'hFFFF_FFFF, 5'h0);
        drive(1'b1, c_rs, 12'hB80, 32'h0, 5'h0);
        check("mcycleh_all_ones", x_rd, 32'hFFFF_FFFF);
        drive(1'b1, c_rs, 12'hB00, 32'h0, 5'h0);
        check("wrap_lo", x_rd, 32'h0);
        drive(1'b1, c_rs, 12'hB80, 32'h0, 5'h0);
        check("wrap_hi", x_rd, 32'h0);

        // Write to read-only cycle shadow is illegal and writes nothing
        drive(1'b1, c_rw, 12'hC00, 32'h55, 5'h0);
        check("cycle_rw_illegal", {31'h0, x_ill}, 32'h1);
        check("cycle_rw_rd", x_rd, 32'h2);
        drive(1'b1, c_rs, 12'hC00, 32'h0, 5'h0);
        check("cycle_rs0_legal", {31'h0, x_ill}, 32'h0);
        check("cycle_rs0_value", x_rd, 32'h3);

        // minstret: counts retire only when not stalled; write beats retire
        @(negedge clk);
        d_is_csr = 1'b0; x_retire = 1'b1;
        @(negedge clk);
        x_stall = 1'b1;
        @(negedge clk);
        x_stall = 1'b0;
        @(negedge clk);
        x_retire = 1'b0;
        d_is_csr = 1'b1; d_fun = c_rs; d_sel = 12'hB02; d_rs1 = 32'h0;
        #1;
        check("minstret_retire", x_rd, 32'h2);
        x_retire = 1'b1;
        drive(1'b1, c_rw, 12'hB02, 32'h50, 5'h0);
        drive(1'b1, c_rs, 12'hC02, 32'h0, 5'h0);
        check("minstret_write_prio", x_rd, 32'h50);
        x_retire = 1'b0;
        drive(1'b1, c_rs, 12'hB82, 32'h0, 5'h0);
        check("minstreth", x_rd, 32'h1 - 32'h1);

        // Reset asserted mid-cycle during a scratch write
        drive(1'b1, c_rw, 12'h340, 32'h0000_AAAA, 5'h0);
        check("pre_reset_scratch", x_rd, 32'h18);
        #2 rst_n = 1'b0;
        #1;
        check("reset_scratch_now", x_rd, 32'h0);
        check("reset_mtvec_now", mtvec, 32'h0000_0100);
        @(negedge clk);
        rst_n = 1'b1;
        d_sel = 12'hB00; d_fun = c_rs; d_rs1 = 32'h0;
        #1;
        check("reset_mcycle_held", x_rd, 32'h0);
        drive(1'b1, c_rs, 12'hB00, 32'h0, 5'h0);
        check("first_inc_after_reset", x_rd, 32'h1);
        drive(1'b1, c_rs, 12'h340, 32'h0, 5'h0);
        check("scratch_write_lost", x_rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/kmkz_csr_file.md
KMKZ_CSR_FILE -- requirements
Module: kmkz_csr_file

Interface
REQ-001 SHALL provide parameter NUM_SCRATCH, default 1, number of scratch registers (1..4); scratch 0 at 0x340, scratch k>0 at 0x7C0+k-1.
REQ-002 SHALL provide parameter CNT_WIDTH, default 64, width of internal mcycle/minstret counters (32..64).
REQ-003 SHALL provide parameter MTVEC_RESET, default 32'h0000_0100, reset value of mtvec.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports x_stall_i, x_kill_i  in  1 each  execute-stage stall / kill qualifiers.
REQ-007 SHALL have ports d_is_csr_i  in  1, d_fun_i  in  3, d_csr_imm_i  in  5, d_csr_sel_i  in  12, d_rs1_i  in  32  decoded CSR operation.
REQ-008 SHALL have port x_retire_i  in  1  one instruction retires this cycle.
REQ-009 SHALL have port csr_time_i  in  40  free-running time.
REQ-010 SHALL have ports csr_mstatus_i, csr_mip_i, csr_mie_i, csr_mepc_i, csr_mcause_i  in  32 each  externally held CSRs.
REQ-011 SHALL have port x_rd_o  out  32  old CSR value to rd.
REQ-012 SHALL have ports x_csr_write_value_o  out  32, x_csr_we_o  out  1, x_csr_sel_o  out  12  write-back for externally held CSRs.
REQ-013 SHALL have ports x_illegal_o  out  1 and csr_mtvec_o  out  32.

Function
REQ-014 SHALL decode: mcycle 0xB00/0xC00, mcycleh 0xB80/0xC80, minstret 0xB02/0xC02, minstreth 0xB82/0xC82, time 0xC01, timeh 0xC81 ({24'h0,time[39:32]}), mtvec 0x305, scratch per REQ-001, and the five external CSRs at 0x300, 0x304, 0x344, 0x341, 0x342.
REQ-015 SHALL make x_rd_o the combinational current value of the selected CSR; counter bits above CNT_WIDTH read 0; undecoded address reads 0.
REQ-016 SHALL compute the new value per d_fun_i: RW/RWI = src; RS/RSI = old|src; RC/RCI = old&~src; src = zero-extended d_csr_imm_i for *I ops, else d_rs1_i.
REQ-017 SHALL treat RS/RC/RSI/RCI with src==0 as read-only accesses (no write, no illegal on read-only CSR).
REQ-018 SHALL assert x_illegal_o combinationally when d_is_csr_i and (address undecoded, or a write to d_csr_sel_i[11:10]==2'b11, or d_fun_i is 3'b000 or 3'b100).
REQ-019 SHALL commit a write only when d_is_csr_i & !x_stall_i & !x_kill_i & !x_illegal_o.
REQ-020 SHALL increment mcycle by 1 every clock, wrapping at 2^CNT_WIDTH to 0.
REQ-021 SHALL increment minstret by 1 on cycles with x_retire_i & !x_stall_i, wrapping likewise.
REQ-022 SHALL give a committed write to a counter half priority over that cycle's increment; the other half holds (no increment that cycle).
REQ-023 SHALL store mtvec with bits [1:0] forced to 0 on write; csr_mtvec_o equals mtvec.
REQ-024 SHALL drive x_csr_we_o high only for a committing write to an external CSR, with x_csr_sel_o = d_csr_sel_i and x_csr_write_value_o = new value.
REQ-025 SHALL ignore writes to scratch addresses at or above NUM_SCRATCH (these are undecoded, hence illegal).

Reset
REQ-026 SHALL, while rst_i is low, clear mcycle, minstret and all scratch registers to 0 and set mtvec to MTVEC_RESET, independent of clk_i.
REQ-027 SHALL abort any in-flight write when reset asserts mid-operation; first increment occurs on the first rising edge after rst_i goes high.

Verification
REQ-028 Release reset, run 10 cycles no CSR ops -> read 0xB00 returns 10 (±pipeline offset fixed by bench), 0xB02 returns 0.
REQ-029 CSRRW 0xB00 with rs1=0xFFFF_FFFF, CNT_WIDTH=64 -> next cycle mcycle low=0xFFFF_FFFF, following cycle low=0, mcycleh=1.
REQ-030 CSRRS 0x340 rs1=0x0F then CSRRC rs1=0x03 -> x_rd_o reads 0x0F, then scratch=0x0C; same op with x_kill_i=1 -> scratch unchanged.
REQ-031 CSRRW 0xC00 -> x_illegal_o=1, no write; CSRRS 0xC00 rs1=0 -> x_illegal_o=0, read returns mcycle.
REQ-032 CSRRWI 0x305 imm=0x13 -> csr_mtvec_o=0x13&~3=0x10; CSRRW 0x341 rs1=0x80 -> x_csr_we_o=1, x_csr_sel_o=0x341, value 0x80 for one cycle.
REQ-033 Assert rst_i low mid-clock during a scratch write -> scratch=0, mtvec=MTVEC_RESET immediately, write lost.
